wishbone_initiator: RTL and testbench
=====================================

# wishbone_initiator

Single-outstanding Wishbone classic-cycle bus master for the crush SoC. It turns a simple valid/ready request port from the CPU load/store path into one Wishbone cycle toward the shared slave bus (memory, peripherals). It terminates that cycle on ack/err/rty and returns a one-cycle response pulse. It retries on `rty_i` up to a bound and, optionally, aborts cycles that no slave terminates.

## Interface
Parameters:
- `MAX_RETRIES`, default 3: number of re-issues after `rty_i` before reporting an error; 0 means no retry.
- `TIMEOUT_CYCLES`, default 256: cycles in BUS without termination before abort; must be ≥ 2. Only used with the timeout feature.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_adr_i`  in  32  byte address.
- `req_sel_i`  in  4  byte lane select.
- `req_dat_i`  in  32  write data.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_err_o`  out  1  qualifies `rsp_valid_o`; 1 = err, retries exhausted, or timeout.
- `rsp_dat_o`  out  32  read data; held until the next response.
- `cyc_o`, `stb_o`, `we_o`  out  1  Wishbone master controls.
- `adr_o`  out  32  Wishbone address.
- `sel_o`  out  4  Wishbone byte select.
- `dat_o`  out  32  Wishbone write data.
- `dat_i`  in  32  Wishbone read data; may be high-Z except in the ack cycle.
- `ack_i`, `err_i`, `rty_i`  in  1  Wishbone cycle terminations.

## Operation
- States are IDLE, BUS and BACKOFF.
- IDLE:
  - `req_ready_o` = 1.
  - On `req_valid_i`, capture we/adr/sel/dat into the Wishbone output registers, clear the retry and timeout counters, and go to BUS.
  - Request inputs are ignored in every other state.
- BUS:
  - `cyc_o` = `stb_o` = 1; the outputs are held stable.
  - Terminations are sampled at each edge, with priority err > ack > rty when several are high at once.
  - `err_i`: response with `rsp_err_o` = 1, `rsp_dat_o` = 0; go to IDLE.
  - `ack_i`: response with `rsp_err_o` = 0. On a read, `rsp_dat_o` = `dat_i`; on a write, `rsp_dat_o` = 0. Go to IDLE.
  - `rty_i`: if retry count < `MAX_RETRIES`, increment it and go to BACKOFF. Otherwise respond with error and go to IDLE.
- BACKOFF: `cyc_o` = `stb_o` = 0 for exactly one cycle, clear the timeout counter, then go to BUS with the same address and data.
- Counter widths are `$clog2(MAX_RETRIES+1)` and `$clog2(TIMEOUT_CYCLES+1)`. Counters saturate and never wrap.
- `dat_i` is sampled only in the ack cycle, so high-Z values elsewhere are never captured.

## Timing
- Reset values: every output is 0, state is IDLE. Exception: `req_ready_o` = 1 one cycle after `rst_ni` deasserts.
- Asserting `rst_ni` low during BUS drops `cyc_o`/`stb_o` immediately and no response is issued.
- Cycle numbering, taking cycle 0 as the edge where the request is accepted:
  - cycle 1: `cyc_o`/`stb_o` high.
  - cycle 2: a registered slave raises `ack_i`.
  - cycle 3: `rsp_valid_o` high, state IDLE, `req_ready_o` high.
  - A new request accepted in cycle 3 drives `stb_o` in cycle 4.
- This gives a minimum 3-cycle request-to-response latency and a minimum one-cycle `stb_o` gap between cycles. The gap is required so registered slaves de-ack.
- `stb_o` deasserts on the cycle after the termination is sampled.
- A response arrives at most 1 + (`MAX_RETRIES`+1)·(`TIMEOUT_CYCLES`+1) cycles after acceptance when the timeout is enabled.

## Configuration
- `WB_INITIATOR_TIMEOUT_EN` defined:
  - The timeout counter increments every BUS cycle.
  - Reaching `TIMEOUT_CYCLES` without termination drops `cyc_o`/`stb_o` and issues an error response (`rsp_dat_o` = 0), with no retry.
- `WB_INITIATOR_TIMEOUT_EN` undefined: there is no counter hardware and BUS waits indefinitely; `TIMEOUT_CYCLES` is ignored.

## Structure
- `crush_wb_pkg` holds:
  - the state encoding localparams (IDLE = 2'd0, BUS = 2'd1, BACKOFF = 2'd2);
  - the data, address and select width constants shared with the bus slaves.
- One sub-module, `wb_timeout_counter` (load/clear, enable, expired flag). It is instantiated only under `WB_INITIATOR_TIMEOUT_EN`.

## Test plan
- Read against the memory slave at 0x0000_0010, preloaded with 0xDEAD_BEEF → `stb_o` high in cycle 1, `rsp_valid_o` in cycle 3, `rsp_dat_o` = 0xDEAD_BEEF, `rsp_err_o` = 0.
- Write 0x1234_5678 with sel 4'b0011, then read back → `rsp_dat_o` = 0xXXXX_5678 with the upper bytes unchanged; at least one cycle with `stb_o` low between the two cycles.
- Slave answers `rty_i` twice, then `ack_i` (`MAX_RETRIES` = 3) → three `stb_o` assertions, each separated by one low cycle, then a good response. With four `rty_i` → exactly 4 assertions and an error response.
- `err_i` and `ack_i` asserted together → error response with `rsp_dat_o` = 0.
- With `WB_INITIATOR_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, address outside all slaves → `cyc_o` drops after 8 BUS cycles, error response, `req_ready_o` high again.
- `rst_ni` pulsed low in the middle of BUS → `cyc_o`/`stb_o` = 0 at once, no `rsp_valid_o`; the next request completes normally.

Source files
------------

// File: rtl/crush_wb_pkg.sv
// crush_wb_pkg: shared Wishbone definitions for the crush SoC bus.
//   - state encoding for the initiator FSM
//   - address / data / select widths shared with the bus slaves
//   - request struct latched by the initiator
package crush_wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUS     = 2'd1;
  localparam logic [1:0] ST_BACKOFF = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    BUS     = ST_BUS,
    BACKOFF = ST_BACKOFF
  } wb_state_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_SW-1:0] sel;
    logic [WB_DW-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: saturating cycle counter that flags a stalled bus cycle.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clr_i          reset the count to 0 (wins over en_i)
//   en_i           count this cycle
//   expired_o      high in the TIMEOUT_CYCLES-th enabled cycle without a clear
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != CW'(TIMEOUT_CYCLES))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // cnt_q counts completed cycles, so the current one is number cnt_q+1.
  assign expired_o = en_i && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wishbone_initiator.sv
// wishbone_initiator: single-outstanding Wishbone classic-cycle master.
// Accepts one request on a valid/ready port, runs one Wishbone cycle, retries
// on rty_i up to MAX_RETRIES times and returns a one-cycle response pulse.
// Optional macro WB_INITIATOR_TIMEOUT_EN aborts cycles that no slave ends
// within TIMEOUT_CYCLES.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   req_valid_i/req_ready_o            request handshake
//   req_we_i/adr_i/sel_i/dat_i         request fields
//   rsp_valid_o/rsp_err_o/rsp_dat_o    response pulse, error flag, read data
//   cyc_o stb_o we_o adr_o sel_o dat_o Wishbone master outputs
//   dat_i ack_i err_i rty_i            Wishbone slave returns
module wishbone_initiator
  import crush_wb_pkg::*;
#(
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [WB_AW-1:0] req_adr_i,
  input  logic [WB_SW-1:0] req_sel_i,
  input  logic [WB_DW-1:0] req_dat_i,
  output logic             rsp_valid_o,
  output logic             rsp_err_o,
  output logic [WB_DW-1:0] rsp_dat_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [WB_AW-1:0] adr_o,
  output logic [WB_SW-1:0] sel_o,
  output logic [WB_DW-1:0] dat_o,
  input  logic [WB_DW-1:0] dat_i,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic             rty_i
);

  // A zero-width counter is illegal; MAX_RETRIES=0 keeps one bit.
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  wb_state_e        state_q, state_d;
  wb_req_t          req_q, req_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             bus_q, bus_d;
  logic             rdy_q, rdy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
  logic             to_exp;

`ifdef WB_INITIATOR_TIMEOUT_EN
  logic to_clr, to_en;

  assign to_en = (state_q == BUS);

  wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_exp)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_exp = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    retry_d     = retry_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
    to_clr      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && rdy_q) begin
          req_d   = '{we: req_we_i, adr: req_adr_i, sel: req_sel_i, dat: req_dat_i};
          retry_d = '0;
          state_d = BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
          to_clr  = 1'b1;
`endif
        end
      end
      BUS: begin
        if (err_i) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = IDLE;
        end else if (ack_i) begin
          // dat_i is only looked at here, where the slave drives it.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = req_q.we ? '0 : dat_i;
          state_d     = IDLE;
        end else if (rty_i) begin
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d = retry_q + RW'(1);
            state_d = BACKOFF;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = '0;
            state_d     = IDLE;
          end
        end else if (to_exp) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = IDLE;
        end
      end
      BACKOFF: begin
        // One idle cycle so a registered slave can drop its rty.
        state_d = BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
        to_clr  = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    bus_d = (state_d == BUS);
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      retry_q     <= '0;
      bus_q       <= 1'b0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      retry_q     <= retry_d;
      bus_q       <= bus_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign req_ready_o = rdy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign cyc_o       = bus_q;
  assign stb_o       = bus_q;
  assign we_o        = req_q.we;
  assign adr_o       = req_q.adr;
  assign sel_o       = req_q.sel;
  assign dat_o       = req_q.dat;

endmodule

// File: tb/tb_wishbone_initiator.sv
// Directed bench for wishbone_initiator with a registered memory slave model.
// Slave modes: 0 ack, 1 rty n times then ack, 2 err+ack together, 3 silent.
module tb_wishbone_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_dat = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat, rdat_bus;
  logic [3:0]  sel;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_rdat;

  int          mode = 0;
  int          rty_n = 0;
  int          rty_cnt;
  logic [31:0] mem [16];

  int n_chk = 0;
  int n_pass = 0;
  int rises = 0;
  logic stb_prev = 1'b0;

  always #5 clk = ~clk;

  wishbone_initiator #(.MAX_RETRIES(3), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_sel_i(req_sel), .req_dat_i(req_dat),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_dat_o(rsp_dat),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel), .dat_o(wdat),
    .dat_i(rdat_bus), .ack_i(s_ack), .err_i(s_err), .rty_i(s_rty)
  );

  // Junk outside the ack cycle must never reach rsp_dat_o.
  assign rdat_bus = s_ack ? s_rdat : 32'hBAD0_BAD0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0; s_rdat <= '0; rty_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEAD_BEEF;
      mem[8] <= 32'hA5A5_0001;
    end else begin
      s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0;
      if (req_valid && req_ready) rty_cnt <= 0;
      if (cyc && stb && !(s_ack || s_err || s_rty)) begin
        if (mode == 3) begin
        end else if (mode == 2) begin
          s_ack <= 1'b1; s_err <= 1'b1; s_rdat <= mem[adr[5:2]];
        end else if (mode == 1 && rty_cnt < rty_n) begin
          s_rty <= 1'b1; rty_cnt <= rty_cnt + 1;
        end else begin
          s_ack <= 1'b1;
          if (we) begin
            for (int b = 0; b < 4; b++)
              if (sel[b]) mem[adr[5:2]][8*b +: 8] <= wdat[8*b +: 8];
          end else s_rdat <= mem[adr[5:2]];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (stb && !stb_prev) rises <= rises + 1;
    stb_prev <= stb;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one request; lat is the cycle number of rsp_valid (accept edge = 0).
  task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output int lat, output logic e,
                      output logic [31:0] rd, output int nst);
    int r0, n;
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_adr = a; req_sel = s; req_dat = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    r0 = rises;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    chk("stb_cycle1", {31'b0, stb}, 32'd1);
    chk("adr_out", adr, a);
    while (!rsp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    e = rsp_err; rd = rsp_dat;
    chk("stb_drop", {31'b0, stb}, 32'd0);
    chk("ready_back", {31'b0, req_ready}, 32'd1);
    nst = rises - r0 + (stb_prev ? 0 : 0);
    // The monitor updates on negedge; let it catch up before reporting.
    @(negedge clk); #1;
    nst = rises - r0;
  endtask

  int lat, nst, nv;
  logic e;
  logic [31:0] rd;

  initial begin
    #12;
    chk("rst_cyc", {31'b0, cyc}, 0);
    chk("rst_ready", {31'b0, req_ready}, 0);
    chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 0);
    chk("rst_dat", rsp_dat, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'b0, req_ready}, 1);

    // Plain read
    mode = 0;
    xact(1'b0, 32'h10, 4'hF, 32'h0, lat, e, rd, nst);
    chk("rd_lat", lat, 3); chk("rd_err", {31'b0, e}, 0); chk("rd_dat", rd, 32'hDEAD_BEEF);

    // Partial write then read back
    xact(1'b1, 32'h10, 4'b0011, 32'h1234_5678, lat, e, rd, nst);
    chk("wr_lat", lat, 3); chk("wr_err", {31'b0, e}, 0); chk("wr_dat", rd, 0);
    xact(1'b0, 32'h10, 4'hF, 32'h0, lat, e, rd, nst);
    chk("rb_dat", rd, 32'hDEAD_5678); chk("rb_nst", nst, 1);

    // Two retries then ack
    mode = 1; rty_n = 2;
    xact(1'b0, 32'h20, 4'hF, 32'h0, lat, e, rd, nst);
    chk("rty2_nst", nst, 3); chk("rty2_lat", lat, 9);
    chk("rty2_err", {31'b0, e}, 0); chk("rty2_dat", rd, 32'hA5A5_0001);

    // Retries exhausted
    rty_n = 4;
    xact(1'b0, 32'h20, 4'hF, 32'h0, lat, e, rd, nst);
    chk("rty4_nst", nst, 4); chk("rty4_lat", lat, 12);
    chk("rty4_err", {31'b0, e}, 1); chk("rty4_dat", rd, 0);

    // err beats ack
    mode = 2;
    xact(1'b0, 32'h10, 4'hF, 32'h0, lat, e, rd, nst);
    chk("errack_lat", lat, 3); chk("errack_err", {31'b0, e}, 1); chk("errack_dat", rd, 0);

`ifdef WB_INITIATOR_TIMEOUT_EN
    mode = 3;
    xact(1'b0, 32'hF000_0000, 4'hF, 32'h0, lat, e, rd, nst);
    chk("to_lat", lat, 9); chk("to_nst", nst, 1);
    chk("to_err", {31'b0, e}, 1); chk("to_dat", rd, 0);
`endif

    // Reset in the middle of BUS
    mode = 3;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h10; req_sel = 4'hF;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("mid_stb_before", {31'b0, stb}, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_cyc", {30'b0, cyc, stb}, 0);
    @(negedge clk); rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) nv++;
    end
    chk("mid_no_rsp", nv, 0);
    mode = 0;
    xact(1'b0, 32'h10, 4'hF, 32'h0, lat, e, rd, nst);
    chk("post_rst_lat", lat, 3); chk("post_rst_err", {31'b0, e}, 0);
    chk("post_rst_dat", rd, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
